// File: rtl/jtdd2_pkg.sv
// Shared types for the Double Dragon 2 main/sub CPU link.
// Halt FSM states, control-register bits and status-byte layout.
package jtdd2_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HREQ   = 2'd1,
    HALTED = 2'd2,
    RESUME = 2'd3
  } halt_st_t;

  localparam int CTL_HALT  = 0;
  localparam int CTL_NMI   = 1;
  localparam int CTL_CLRTO = 2;

  localparam int ST_IRQ    = 0;
  localparam int ST_NMI    = 1;
  localparam int ST_HALTED = 2;
  localparam int ST_WAITTO = 3;

  typedef struct packed {
    logic wait_to;
    logic halted;
    logic nmi_busy;
    logic irq;
  } status_t;

  function automatic logic [7:0] status_byte(status_t s);
    return {4'b0, s};
  endfunction

endpackage

// File: rtl/jtdd2_subcom_halt.sv
// Sub CPU halt handshake: request, wait for an idle sub bus,
// acknowledge, then a one-cycle settle on release.
module jtdd2_subcom_halt
  import jtdd2_pkg::*;
#(
  parameter int HALT_DLY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cen4,
  input  logic halt_req,
  input  logic mcu_ban,
  output logic mcu_halt,
  output logic halted
);

  localparam int HW = $clog2(HALT_DLY + 1);
  localparam logic [HW-1:0] LAST = HW'(HALT_DLY - 1);

  halt_st_t        st;
  logic [HW-1:0]   idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= RUN;
      idle     <= '0;
      mcu_halt <= 1'b0;
      halted   <= 1'b0;
    end else begin
      unique case (st)
        RUN: begin
          if (halt_req) begin
            st       <= HREQ;
            mcu_halt <= 1'b1;
            idle     <= '0;
          end
        end
        HREQ: begin
          if (!halt_req) begin
            st       <= RUN;
            mcu_halt <= 1'b0;
          end else if (mcu_ban) begin
            idle <= '0;
          end else if (cen4) begin
            // Nth consecutive idle tick grants the halt
            if (idle == LAST) begin
              st     <= HALTED;
              halted <= 1'b1;
              idle   <= '0;
            end else begin
              idle <= idle + 1'b1;
            end
          end
        end
        HALTED: begin
          if (!halt_req) begin
            st       <= RESUME;
            mcu_halt <= 1'b0;
            halted   <= 1'b0;
          end
        end
        RESUME: begin
          st <= RUN;
        end
        default: begin
          st       <= RUN;
          mcu_halt <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/jtdd2_subcom.sv
// Main-CPU side of the DD2 sub-CPU link: control decode, NMI
// stretcher, IRQ latch and shared-RAM stall arbitration.
module jtdd2_subcom
  import jtdd2_pkg::*;
#(
  parameter int NMI_LEN  = 8,
  parameter int HALT_DLY = 4,
  parameter int WAIT_MAX = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen4,
  input  logic       main_wrn,
  input  logic [7:0] main_dout,
  input  logic       ctl_cs,
  input  logic       ack_cs,
  input  logic       com_cs_in,
  output logic       com_cs,
  output logic       main_wait,
  input  logic       mcu_ban,
  input  logic       mcu_irqmain,
  output logic       mcu_nmi_set,
  output logic       mcu_halt,
  output logic       main_irq,
  output logic [7:0] ctl_dout
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WLAST = WW'(WAIT_MAX - 1);

  logic          ctl_wr;
  logic          wr_l;
  logic          ctl_we;
  logic [1:0]    ctl;
  logic          halt_req;
  logic          nmi_trig;
  logic [7:0]    nmi_cnt;
  logic          irq_l;
  logic          irq_rise;
  logic          ack_wr;
  logic [WW-1:0] wcnt;
  logic          timeout;
  logic          wait_to;
  logic          to_hit;
  logic          to_clr;
  logic          halted;
  status_t       sts;
  logic          unused_dout;

  assign unused_dout = ^main_dout[7:3];

  // A long write strobe must act only once
  assign ctl_wr   = ctl_cs & ~main_wrn;
  assign ctl_we   = ctl_wr & ~wr_l;
  assign halt_req = ctl_we ? main_dout[CTL_HALT]
                           : ctl[CTL_HALT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_l <= 1'b0;
      ctl  <= 2'b0;
    end else begin
      wr_l <= ctl_wr;
      if (ctl_we) ctl <= main_dout[1:0];
    end
  end

  assign nmi_trig = ctl_we & main_dout[CTL_NMI]
                  & ~ctl[CTL_NMI] & ~mcu_nmi_set;
  assign mcu_nmi_set = |nmi_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_cnt <= 8'd0;
    end else if (nmi_trig) begin
      nmi_cnt <= 8'(NMI_LEN);
    end else if (cen4 && mcu_nmi_set) begin
      nmi_cnt <= nmi_cnt - 8'd1;
    end
  end

  assign irq_rise = mcu_irqmain & ~irq_l;
  assign ack_wr   = ack_cs & ~main_wrn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_l    <= 1'b0;
      main_irq <= 1'b0;
    end else begin
      irq_l <= mcu_irqmain;
      if (irq_rise)    main_irq <= 1'b1;
      else if (ack_wr) main_irq <= 1'b0;
    end
  end

  jtdd2_subcom_halt #(
    .HALT_DLY (HALT_DLY)
  ) u_halt (
    .clk      (clk),
    .rst      (rst),
    .cen4     (cen4),
    .halt_req (halt_req),
    .mcu_ban  (mcu_ban),
    .mcu_halt (mcu_halt),
    .halted   (halted)
  );

  // Deadlock guard: give the main CPU the bus after WAIT_MAX cycles
  assign to_hit = com_cs_in & mcu_ban & ~timeout
                & (wcnt == WLAST);
  assign to_clr = ctl_we & main_dout[CTL_CLRTO];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      timeout <= 1'b0;
      wait_to <= 1'b0;
    end else begin
      if (!com_cs_in) begin
        wcnt    <= '0;
        timeout <= 1'b0;
      end else if (mcu_ban && !timeout) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == WLAST) timeout <= 1'b1;
      end
      if (to_hit)      wait_to <= 1'b1;
      else if (to_clr) wait_to <= 1'b0;
    end
  end

  assign main_wait = ~rst & com_cs_in & mcu_ban
                   & ~halted & ~timeout;
  assign com_cs    = ~rst & com_cs_in & ~main_wait;

  assign sts      = {wait_to, halted, mcu_nmi_set, main_irq};
  assign ctl_dout = status_byte(sts);

endmodule
